// File: rtl/regbus_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : regbus_rr_arbiter
// Brief    : Round-robin arbiter sharing one internal register bus between
//            N_REQ requesters. Serialises one transaction at a time, drives
//            one-cycle registered strobes, collects read data after RD_LAT
//            cycles and returns a one-cycle response pulse to the requester.
// Revision : 1.0 - initial release
// ============================================================================
module regbus_rr_arbiter #(
  parameter int N_REQ      = 2,
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 32,
  parameter int RD_LAT     = 2
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [N_REQ-1:0]              req_valid,
  input  logic [N_REQ-1:0]              req_we,
  input  logic [N_REQ*ADDR_WIDTH-1:0]   req_addr,
  input  logic [N_REQ*DATA_WIDTH-1:0]   req_wdata,
  output logic [N_REQ-1:0]              req_ready,
  output logic [N_REQ-1:0]              rsp_valid,
  output logic [DATA_WIDTH-1:0]         rsp_rdata,
  output logic [ADDR_WIDTH-1:0]         bus_addr,
  output logic [DATA_WIDTH-1:0]         bus_wdata,
  output logic                          bus_wr_en,
  output logic                          bus_rd_en,
  input  logic [DATA_WIDTH-1:0]         bus_rdata,
  output logic [$clog2(N_REQ)-1:0]      grant_id,
  output logic                          busy
);

  localparam int                ID_W      = $clog2(N_REQ);
  localparam int                CNT_W     = 3;
  localparam logic [CNT_W-1:0]  CNT_LOAD  = CNT_W'(RD_LAT - 1);
  localparam logic [ID_W:0]     N_REQ_EXT = (ID_W+1)'(N_REQ);
  localparam logic [ID_W-1:0]   LAST_ID   = ID_W'(N_REQ - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STROBE = 2'd1,
    WAIT   = 2'd2,
    RESP   = 2'd3
  } state_t;

  state_t                  state_q, state_d;
  logic [ID_W-1:0]         rr_ptr_q, rr_ptr_d;
  logic [ID_W-1:0]         grant_id_q, grant_id_d;
  logic                    we_q, we_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [N_REQ-1:0]        req_ready_q, req_ready_d;
  logic [N_REQ-1:0]        rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0]   rsp_rdata_q, rsp_rdata_d;
  logic [ADDR_WIDTH-1:0]   bus_addr_q, bus_addr_d;
  logic [DATA_WIDTH-1:0]   bus_wdata_q, bus_wdata_d;
  logic                    bus_wr_en_q, bus_wr_en_d;
  logic                    bus_rd_en_q, bus_rd_en_d;
  logic                    busy_q, busy_d;

  logic                    arb_found;
  logic [ID_W-1:0]         arb_idx;
  logic [ID_W:0]           arb_pos;
  logic [ADDR_WIDTH-1:0]   sel_addr;
  logic [DATA_WIDTH-1:0]   sel_wdata;

  // Pick the first pending requester searching cyclically upward from rr_ptr.
  always_comb begin
    arb_found = 1'b0;
    arb_idx   = '0;
    arb_pos   = '0;
    for (int k = 0; k < N_REQ; k++) begin
      arb_pos = {1'b0, rr_ptr_q} + (ID_W+1)'(k);
      if (arb_pos >= N_REQ_EXT) begin
        arb_pos = arb_pos - N_REQ_EXT;
      end
      if (!arb_found && req_valid[arb_pos[ID_W-1:0]]) begin
        arb_found = 1'b1;
        arb_idx   = arb_pos[ID_W-1:0];
      end
    end
  end

  assign sel_addr  = req_addr[arb_idx*ADDR_WIDTH +: ADDR_WIDTH];
  assign sel_wdata = req_wdata[arb_idx*DATA_WIDTH +: DATA_WIDTH];

  // Next-state and next-output logic; every output is computed one cycle
  // ahead so that the registered copy lines up with the state it belongs to.
  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    grant_id_d  = grant_id_q;
    we_d        = we_q;
    cnt_d       = cnt_q;
    req_ready_d = '0;
    rsp_valid_d = '0;
    rsp_rdata_d = rsp_rdata_q;
    bus_addr_d  = '0;
    bus_wdata_d = '0;
    bus_wr_en_d = 1'b0;
    bus_rd_en_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (arb_found) begin
          grant_id_d           = arb_idx;
          we_d                 = req_we[arb_idx];
          bus_addr_d           = sel_addr;
          bus_wdata_d          = sel_wdata;
          bus_wr_en_d          = req_we[arb_idx];
          bus_rd_en_d          = !req_we[arb_idx];
          req_ready_d[arb_idx] = 1'b1;
          state_d              = STROBE;
        end
      end
      STROBE: begin
        // The requester just served drops to lowest priority.
        rr_ptr_d = (grant_id_q == LAST_ID) ? '0 : grant_id_q + 1'b1;
        if (we_q) begin
          rsp_valid_d[grant_id_q] = 1'b1;
          state_d                 = RESP;
        end else begin
          cnt_d   = CNT_LOAD;
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (cnt_q == '0) begin
          rsp_rdata_d             = bus_rdata;
          rsp_valid_d[grant_id_q] = 1'b1;
          state_d                 = RESP;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  // State and output registers; reset aborts any transaction immediately.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      rr_ptr_q    <= '0;
      grant_id_q  <= '0;
      we_q        <= 1'b0;
      cnt_q       <= '0;
      req_ready_q <= '0;
      rsp_valid_q <= '0;
      rsp_rdata_q <= '0;
      bus_addr_q  <= '0;
      bus_wdata_q <= '0;
      bus_wr_en_q <= 1'b0;
      bus_rd_en_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      grant_id_q  <= grant_id_d;
      we_q        <= we_d;
      cnt_q       <= cnt_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      bus_addr_q  <= bus_addr_d;
      bus_wdata_q <= bus_wdata_d;
      bus_wr_en_q <= bus_wr_en_d;
      bus_rd_en_q <= bus_rd_en_d;
      busy_q      <= busy_d;
    end
  end

  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign bus_addr  = bus_addr_q;
  assign bus_wdata = bus_wdata_q;
  assign bus_wr_en = bus_wr_en_q;
  assign bus_rd_en = bus_rd_en_q;
  assign grant_id  = grant_id_q;
  assign busy      = busy_q;

endmodule
`default_nettype wire
